// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and FSM state type for the round-robin grant arbiter
package arb_pkg;
    localparam int NREQ = 8;
    localparam int IDX_W = 3;
    localparam int MAX_HOLD = 16;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/done/grant bundle between requesters and the arbiter
interface rr_grant_arbiter_if;
    import arb_pkg::*;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic gnt_valid;
    logic timeout;
    modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_arbiter_grant_decoder.sv
// grant_decoder: 3-to-8 one-hot decoder with enable, all zeros when disabled
module grant_decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREQ-1:0]  onehot
);
    assign onehot = en ? {{(NREQ-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 8-way round-robin arbiter with done handshake and one idle turnaround per grant
// Define ARB_TIMEOUT_EN to add a watchdog that revokes grants held MAX_HOLD cycles.
module rr_grant_arbiter
    import arb_pkg::*;
(
    input logic clk,
    input logic rst,
    rr_grant_arbiter_if.slave bus
);
    state_t state, state_n;
    logic [IDX_W-1:0] idx_q, idx_n, ptr, ptr_n;
    logic valid_q, valid_n, rel, to_n;
    logic [NREQ-1:0] gnt_w;
    // lowest offset from p wins; scanning downwards lets the last hit be the first in rotation
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] k;
        rr_pick = p;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = p + IDX_W'(i);
            if (r[k]) rr_pick = k;
        end
    endfunction
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0] cnt, cnt_n;
    logic expire, to_q;
    assign expire = (state == GRANT) && (cnt == CW'(MAX_HOLD - 1));
    assign cnt_n = (state == GRANT) ? cnt + 1'b1 : '0;
    assign to_n = expire && !bus.done[idx_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            to_q <= 1'b0;
        end else begin
            cnt <= cnt_n;
            to_q <= to_n;
        end
    end
    assign bus.timeout = to_q;
    assign rel = bus.done[idx_q] || expire;
`else
    assign to_n = 1'b0;
    assign bus.timeout = to_n;
    assign rel = bus.done[idx_q];
`endif
    always_comb begin
        state_n = state;
        idx_n = idx_q;
        valid_n = valid_q;
        ptr_n = ptr;
        if (state == IDLE) begin
            if (|bus.req) begin
                idx_n = rr_pick(bus.req, ptr);
                valid_n = 1'b1;
                state_n = GRANT;
            end
        end else if (rel) begin
            valid_n = 1'b0;
            ptr_n = idx_q + 1'b1;
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx_q <= '0;
            valid_q <= 1'b0;
            ptr <= '0;
        end else begin
            state <= state_n;
            idx_q <= idx_n;
            valid_q <= valid_n;
            ptr <= ptr_n;
        end
    end
    grant_decoder u_dec (.idx(idx_q), .en(valid_q), .onehot(gnt_w));
    assign bus.gnt = gnt_w;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_valid = valid_q;
endmodule
